// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants, state encoding and sizing helpers for the memory bus arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_bus_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Timeout counter width; a disabled timeout still needs a 1-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    // Channel index width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_picker.sv
// Combinational winner selection among eligible channels (fixed priority or round-robin).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to consume the winner.
module arb_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int MODE = ARB_FIXED,
    localparam int PW  = idx_width(NCH)
) (
    input  logic [NCH-1:0] i_eligible,
    input  logic [PW-1:0]  i_rr_ptr,
    output logic [NCH-1:0] o_win_oh,
    output logic [PW-1:0]  o_win_idx,
    output logic           o_win_vld
);

    int          w_base;
    int          w_idx;
    logic [PW-1:0] w_sel;

    // Scan channels starting at the base (0 for fixed priority, rr pointer otherwise), first hit wins.
    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        o_win_vld = 1'b0;
        w_base    = (MODE == ARB_RR) ? int'(i_rr_ptr) : 0;
        w_idx     = 0;
        w_sel     = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = w_base + k;
            if (w_idx >= NCH) begin
                w_idx = w_idx - NCH;
            end
            w_sel = PW'(w_idx);
            if (!o_win_vld && i_eligible[w_sel]) begin
                o_win_vld       = 1'b1;
                o_win_oh[w_sel] = 1'b1;
                o_win_idx       = w_sel;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port among NCH requestors with optional per-transaction timeout.
// Latency: request sampled at edge T, strobes from T+1, ready earliest in cycle T+2.
// Backpressure: requestors hold req until their ready pulse; memory stalls by holding mem_ready low.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MODE    = ARB_FIXED,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ready,
    output logic [NCH-1:0]    err,
    output logic [DW-1:0]     rdata,
    output logic [NCH-1:0]    grant,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_data_in,
    output logic              mem_wr,
    output logic              mem_re,
    input  logic [DW-1:0]     mem_data_out,
    input  logic              mem_ready
);

    localparam int            PW     = idx_width(NCH);
    localparam int            CW     = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST   = PW'(NCH - 1);

    arb_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_gidx;
    logic [NCH-1:0]  r_grant;
    logic [NCH-1:0]  r_ready;
    logic [NCH-1:0]  r_err;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   r_wdat;
    logic [AW-1:0]   r_addr;
    logic            r_wr;
    logic            r_re;

    logic [NCH-1:0]  w_eligible;
    logic [NCH-1:0]  w_win_oh;
    logic [PW-1:0]   w_win_idx;
    logic            w_win_vld;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_we;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_timeout;

    // A channel in its own completion cycle is not eligible, so it cannot be re-accepted immediately.
    assign w_eligible = req & ~r_ready;

    arb_picker #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_ptr),
        .o_win_oh   (w_win_oh),
        .o_win_idx  (w_win_idx),
        .o_win_vld  (w_win_vld)
    );

    // One-hot mux of the winning channel's address, data and direction.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_win_oh[i]) begin
                w_sel_addr  = ch_addr[i*AW +: AW];
                w_sel_wdata = ch_wdata[i*DW +: DW];
                w_sel_we    = we[i];
            end
        end
    end

    // Saturating counter; abort fires on the edge where the count would reach TIMEOUT.
    assign w_cnt_nxt = (r_cnt == TO_VAL) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_nxt == TO_VAL);

    // IDLE/BUSY state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_ready <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            r_wdat  <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_re    <= 1'b0;
        end else begin
            r_ready <= '0;
            r_err   <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_vld) begin
                        r_grant <= w_win_oh;
                        r_gidx  <= w_win_idx;
                        r_addr  <= w_sel_addr;
                        r_wdat  <= w_sel_wdata;
                        r_wr    <= w_sel_we;
                        r_re    <= ~w_sel_we;
                        r_cnt   <= '0;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ready || w_timeout) begin
                        r_ready <= r_grant;
                        r_grant <= '0;
                        r_wr    <= 1'b0;
                        r_re    <= 1'b0;
                        r_ptr   <= (r_gidx == LAST) ? '0 : r_gidx + 1'b1;
                        r_state <= ARB_IDLE;
                        if (mem_ready) begin
                            if (r_re) begin
                                r_rdata <= mem_data_out;
                            end
                        end else begin
                            r_err   <= r_grant;
                            r_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign grant       = r_grant;
    assign mem_addr    = r_addr;
    assign mem_data_in = r_wdat;
    assign mem_wr      = r_wr;
    assign mem_re      = r_re;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: 2-channel fixed-priority instance (TIMEOUT=4) and 4-channel round-robin instance.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Every wait is a fixed number of cycles, so the run always terminates.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: NCH=2, MODE=0, TIMEOUT=4
    logic [1:0]  a_req = '0, a_we = '0;
    logic [63:0] a_addr = '0, a_wdata = '0;
    logic [1:0]  a_ready, a_err, a_grant;
    logic [31:0] a_rdata, a_mem_addr, a_mem_din;
    logic        a_mem_wr, a_mem_re;
    logic [31:0] a_mem_dout = '0;
    logic        a_mem_rdy = 1'b0;

    // Instance B: NCH=4, MODE=1, TIMEOUT=255
    logic [3:0]   b_req = '0, b_we = '0;
    logic [127:0] b_addr = '0, b_wdata = '0;
    logic [3:0]   b_ready, b_err, b_grant;
    logic [31:0]  b_rdata, b_mem_addr, b_mem_din;
    logic         b_mem_wr, b_mem_re;
    logic [31:0]  b_mem_dout = '0;
    logic         b_mem_rdy = 1'b0;

    mem_bus_arbiter #(.NCH(2), .AW(32), .DW(32), .MODE(0), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .we(a_we), .ch_addr(a_addr), .ch_wdata(a_wdata),
        .ready(a_ready), .err(a_err), .rdata(a_rdata), .grant(a_grant),
        .mem_addr(a_mem_addr), .mem_data_in(a_mem_din), .mem_wr(a_mem_wr), .mem_re(a_mem_re),
        .mem_data_out(a_mem_dout), .mem_ready(a_mem_rdy)
    );

    mem_bus_arbiter #(.NCH(4), .AW(32), .DW(32), .MODE(1), .TIMEOUT(255)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .we(b_we), .ch_addr(b_addr), .ch_wdata(b_wdata),
        .ready(b_ready), .err(b_err), .rdata(b_rdata), .grant(b_grant),
        .mem_addr(b_mem_addr), .mem_data_in(b_mem_din), .mem_wr(b_mem_wr), .mem_re(b_mem_re),
        .mem_data_out(b_mem_dout), .mem_ready(b_mem_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            b_addr[i*32 +: 32] = 32'(32'h1000 + 4 * i);
        end
        b_mem_dout = 32'h12345678;

        // Reset
        tick();
        tick();
        chk("rst_a_ready", 64'(a_ready),    64'(0));
        chk("rst_a_grant", 64'(a_grant),    64'(0));
        chk("rst_a_addr",  64'(a_mem_addr), 64'(0));
        chk("rst_a_rdata", 64'(a_rdata),    64'(0));
        chk("rst_a_re",    64'(a_mem_re),   64'(0));
        chk("rst_b_grant", 64'(b_grant),    64'(0));
        rst = 1'b1;

        // Single read on channel 0, memory answers in the first BUSY cycle
        a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h100; a_mem_dout = 32'hDEADBEEF;
        tick();
        chk("rd_grant", 64'(a_grant),    64'(2'b01));
        chk("rd_re",    64'(a_mem_re),   64'(1));
        chk("rd_wr",    64'(a_mem_wr),   64'(0));
        chk("rd_addr",  64'(a_mem_addr), 64'(32'h100));
        chk("rd_ready0",64'(a_ready),    64'(0));
        a_mem_rdy = 1'b1;
        tick();
        chk("rd_ready", 64'(a_ready),    64'(2'b01));
        chk("rd_err",   64'(a_err),      64'(0));
        chk("rd_rdata", 64'(a_rdata),    64'(32'hDEADBEEF));
        chk("rd_ungrant", 64'(a_grant),  64'(0));
        chk("rd_re_off",64'(a_mem_re),   64'(0));
        a_req = 2'b00; a_mem_rdy = 1'b0;
        tick();
        chk("rd_ready_pulse", 64'(a_ready), 64'(0));
        chk("rd_rdata_hold",  64'(a_rdata), 64'(32'hDEADBEEF));

        // mem_ready while idle has no effect
        a_mem_rdy = 1'b1;
        tick();
        chk("idle_memrdy_ready", 64'(a_ready), 64'(0));
        chk("idle_memrdy_grant", 64'(a_grant), 64'(0));
        a_mem_rdy = 1'b0;

        // Fixed priority, both held, memory takes 2 BUSY cycles.
        // Channel 0 wins from idle; channel 1 is accepted in channel 0's completion cycle.
        a_req = 2'b11; a_addr[31:0] = 32'h200; a_addr[63:32] = 32'h300; a_mem_dout = 32'h11112222;
        tick();
        chk("fp_grant_a", 64'(a_grant),    64'(2'b01));
        chk("fp_addr_a",  64'(a_mem_addr), 64'(32'h200));
        tick();
        chk("fp_busy_a",  64'(a_grant),    64'(2'b01));
        chk("fp_noready", 64'(a_ready),    64'(0));
        a_mem_rdy = 1'b1;
        tick();
        chk("fp_ready_a", 64'(a_ready),    64'(2'b01));
        chk("fp_rdata_a", 64'(a_rdata),    64'(32'h11112222));
        chk("fp_idle_a",  64'(a_grant),    64'(0));
        a_mem_rdy = 1'b0;
        tick();
        chk("fp_grant_b", 64'(a_grant),    64'(2'b10));
        chk("fp_addr_b",  64'(a_mem_addr), 64'(32'h300));
        tick();
        a_mem_rdy = 1'b1;
        tick();
        chk("fp_ready_b", 64'(a_ready),    64'(2'b10));
        a_mem_rdy = 1'b0;
        tick();
        chk("fp_grant_c", 64'(a_grant),    64'(2'b01));
        a_mem_rdy = 1'b1;
        tick();
        chk("fp_ready_c", 64'(a_ready),    64'(2'b01));
        a_req = 2'b00; a_mem_rdy = 1'b0;
        tick();
        chk("fp_done",    64'(a_grant),    64'(0));

        // Write on channel 1 with input changes and req drop during BUSY
        a_req = 2'b10; a_we = 2'b10; a_addr[63:32] = 32'h20; a_wdata[63:32] = 32'h55;
        a_mem_dout = 32'hCAFEF00D;
        tick();
        chk("wr_grant", 64'(a_grant),    64'(2'b10));
        chk("wr_wr",    64'(a_mem_wr),   64'(1));
        chk("wr_re",    64'(a_mem_re),   64'(0));
        chk("wr_addr",  64'(a_mem_addr), 64'(32'h20));
        chk("wr_data",  64'(a_mem_din),  64'(32'h55));
        a_addr[63:32] = 32'h99; a_wdata[63:32] = 32'hAA;
        tick();
        chk("wr_addr_stable1", 64'(a_mem_addr), 64'(32'h20));
        a_req = 2'b00;
        tick();
        chk("wr_wr_held",      64'(a_mem_wr),   64'(1));
        chk("wr_addr_stable2", 64'(a_mem_addr), 64'(32'h20));
        chk("wr_data_stable",  64'(a_mem_din),  64'(32'h55));
        chk("wr_grant_held",   64'(a_grant),    64'(2'b10));
        a_mem_rdy = 1'b1;
        tick();
        chk("wr_ready",      64'(a_ready),  64'(2'b10));
        chk("wr_rdata_hold", 64'(a_rdata),  64'(32'h11112222));
        chk("wr_wr_off",     64'(a_mem_wr), 64'(0));
        chk("wr_err",        64'(a_err),    64'(0));
        a_mem_rdy = 1'b0; a_we = 2'b00;
        tick();
        chk("wr_ready_pulse", 64'(a_ready), 64'(0));

        // Timeout: memory never answers, abort after 4 BUSY cycles
        a_req = 2'b01; a_addr[31:0] = 32'h40;
        tick();
        chk("to_grant", 64'(a_grant), 64'(2'b01));
        tick();
        tick();
        tick();
        chk("to_still_busy", 64'(a_grant), 64'(2'b01));
        chk("to_no_ready",   64'(a_ready), 64'(0));
        tick();
        chk("to_ready", 64'(a_ready),  64'(2'b01));
        chk("to_err",   64'(a_err),    64'(2'b01));
        chk("to_rdata", 64'(a_rdata),  64'(0));
        chk("to_idle",  64'(a_grant),  64'(0));
        chk("to_re",    64'(a_mem_re), 64'(0));
        a_req = 2'b00;
        tick();
        chk("to_err_pulse", 64'(a_err), 64'(0));

        // Round-robin over 4 channels with all requests held, 1-cycle memory
        b_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("rr_grant%0d", n), 64'(b_grant),    64'(4'b0001 << (n % 4)));
            chk($sformatf("rr_addr%0d", n),  64'(b_mem_addr), 64'(32'h1000 + 4 * (n % 4)));
            chk($sformatf("rr_noready%0d", n), 64'(b_ready),  64'(0));
            b_mem_rdy = 1'b1;
            tick();
            chk($sformatf("rr_ready%0d", n), 64'(b_ready),    64'(4'b0001 << (n % 4)));
            chk($sformatf("rr_idle%0d", n),  64'(b_grant),    64'(0));
            b_mem_rdy = 1'b0;
        end
        b_req = 4'b0000;
        tick();

        // Reset mid-transaction drops it and clears the rr pointer
        b_req = 4'b0100;
        tick();
        chk("mr_grant", 64'(b_grant), 64'(4'b0100));
        rst = 1'b0; b_mem_rdy = 1'b1;
        tick();
        chk("mr_ready", 64'(b_ready),    64'(0));
        chk("mr_grant0",64'(b_grant),    64'(0));
        chk("mr_re",    64'(b_mem_re),   64'(0));
        chk("mr_addr",  64'(b_mem_addr), 64'(0));
        chk("mr_rdata", 64'(b_rdata),    64'(0));
        rst = 1'b1; b_mem_rdy = 1'b0; b_req = 4'b1001;
        tick();
        chk("mr_no_late_ready", 64'(b_ready), 64'(0));
        chk("mr_ptr_zero",      64'(b_grant), 64'(4'b0001));
        b_mem_rdy = 1'b1;
        tick();
        chk("mr_after_ready",   64'(b_ready), 64'(4'b0001));
        b_mem_rdy = 1'b0; b_req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
